ccff_chain_loader: RTL and testbench

- Configuration-chain programming controller that drives `ccff_head` of a connection/switch-block configuration chain.
- Accepts bitstream words over a valid/ready interface, serializes them LSB-first onto `ccff_head` and asserts a per-bit shift enable.
- Counts exactly `CHAIN_LEN` bits, then reports completion.
- Sits directly upstream of the routing-block memory chain; the chain's `ccff_tail` feeds back for the optional integrity check.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_word_serializer.sv | 36 +++
 rtl/ccff_chain_loader.sv | 120 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// The CCFF_READBACK_EN build option doubles the load length (see bits_per_load).
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned CHAIN_LEN_DEF = 36;
  localparam int unsigned DATA_W_DEF    = 8;

  // With readback the bitstream goes through twice, so the second pass can be checked at the tail
  function automatic int unsigned bits_per_load(input int unsigned chain_len, input bit readback);
    return readback ? 2 * chain_len : chain_len;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Captures one bitstream word and presents it LSB-first, one bit per shift.
// Tracks the bit position inside the word and flags the word's final bit.
module ccff_word_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] sreg;
  logic [IDX_W-1:0]  bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sreg    <= data;
      bit_idx <= '0;
    end else if (shift) begin
      sreg    <= sreg >> 1;
      bit_idx <= bit_idx + 1'b1;
    end
  end

  assign bit_out = sreg[0];
  assign last    = (bit_idx == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Programs a routing-block configuration chain from a valid/ready word stream.
// Build option CCFF_READBACK_EN: send the stream twice and check ccff_tail on the second pass.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
`ifdef CCFF_READBACK_EN
  output logic              readback_err,
`endif
  output logic              done
);

`ifdef CCFF_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  localparam int unsigned     LOAD_BITS = bits_per_load(CHAIN_LEN, READBACK);
  localparam int unsigned     CNT_W     = $clog2(LOAD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_BITS - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             ser_bit;
  logic             ser_last;

  ccff_word_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk    (prog_clk),
    .rst_n  (prog_rst_n),
    .load   ((state == FETCH) && cfg_valid),
    .data   (cfg_data),
    .shift  (state == SHIFT),
    .bit_out(ser_bit),
    .last   (ser_last)
  );

`ifdef CCFF_READBACK_EN
  logic check_en;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state         <= IDLE;
      cfg_ready     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bit_cnt       <= '0;
`ifdef CCFF_READBACK_EN
      check_en      <= 1'b0;
      readback_err  <= 1'b0;
`endif
    end else begin
      ccff_shift_en <= 1'b0;
`ifdef CCFF_READBACK_EN
      // check_en is aligned with the registered head bit, so tail is compared while that bit is on the wire
      check_en <= 1'b0;
      if (check_en && (ccff_tail != ccff_head))
        readback_err <= 1'b1;
`endif
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= FETCH;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_cnt   <= '0;
`ifdef CCFF_READBACK_EN
            readback_err <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            state     <= SHIFT;
            cfg_ready <= 1'b0;
          end
        end
        SHIFT: begin
          ccff_head     <= ser_bit;
          ccff_shift_en <= 1'b1;
          bit_cnt       <= bit_cnt + 1'b1;
`ifdef CCFF_READBACK_EN
          check_en      <= (bit_cnt >= CNT_W'(CHAIN_LEN));
`endif
          if (bit_cnt == LAST_CNT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (ser_last) begin
            state     <= FETCH;
            cfg_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed self-checking bench for ccff_chain_loader, with an ideal chain model driving ccff_tail.
// Readback scenarios are compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_EN
  localparam int LOAD = 72;
  localparam int NW   = 9;
`else
  localparam int LOAD = 36;
  localparam int NW   = 5;
`endif
  localparam int SPAN = LOAD + NW - 1;
  localparam logic [35:0] S     = 36'h9_00_FF_3C_A5;
  localparam logic [35:0] S_BAD = 36'h9_00_FF_BC_A5;

  logic       prog_clk = 1'b0;
  logic       prog_rst_n;
  logic       start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       busy;
  logic       done;
`ifdef CCFF_READBACK_EN
  logic       readback_err;
`endif

  ccff_chain_loader #(
    .CHAIN_LEN(36),
    .DATA_W   (8)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_rst_n   (prog_rst_n),
    .start        (start),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
`ifdef CCFF_READBACK_EN
    .readback_err (readback_err),
`endif
    .done         (done)
  );

  always #5 prog_clk = ~prog_clk;

  // 36-stage chain model; stage 20 optionally stuck at 0
  logic [35:0] chain = '0;
  logic [35:0] chain_nx;
  logic        stuck = 1'b0;
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain_nx = {chain[34:0], ccff_head};
      if (stuck) chain_nx[20] = 1'b0;
      chain <= chain_nx;
    end
  end
  assign ccff_tail = chain[35];

  int          cyc = 0, nen = 0, hs = 0, first_t = 0, last_t = 0;
  logic [79:0] rec = '0;
  logic        mon_clr = 1'b0;
  logic        abort_prod = 1'b0;
  int          nchk = 0, npass = 0;

  always @(posedge prog_clk) begin
    cyc++;
    if (mon_clr) hs = 0;
    else if (cfg_valid && cfg_ready) hs++;
  end

  always @(negedge prog_clk) begin
    if (mon_clr) begin
      nen = 0;
      rec = '0;
    end else if (ccff_shift_en) begin
      if (nen < 80) rec[nen] = ccff_head;
      if (nen == 0) first_t = cyc;
      last_t = cyc;
      nen++;
    end
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge prog_clk);
    @(negedge prog_clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge prog_clk);
    #1 start = 1'b1;
    @(posedge prog_clk);
    #1 start = 1'b0;
  endtask

  // Offers one word each time the loader is ready; word stall_at is held back stall_n ready cycles
  task automatic produce(input logic [79:0] strm, input int nw, input int stall_at, input int stall_n);
    for (int i = 0; i < nw; i++) begin
      int idle;
      int g;
      bit acc;
      idle = 0;
      g    = 0;
      acc  = 1'b0;
      cfg_data = strm[i*8 +: 8];
      while (!acc && !abort_prod && g < 300) begin
        @(negedge prog_clk);
        g++;
        if (cfg_ready && !abort_prod) begin
          if (i != stall_at || idle >= stall_n) begin
            cfg_valid = 1'b1;
            acc       = 1'b1;
          end else begin
            idle++;
          end
        end
      end
      if (acc) begin
        @(posedge prog_clk);
        #1 cfg_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400 && done !== 1'b1; c++) @(negedge prog_clk);
    @(negedge prog_clk);
  endtask

  logic [79:0] strm_good;
  logic [79:0] strm_bad;

  initial begin
    prog_rst_n = 1'b0;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    strm_good  = '0;
    strm_bad   = '0;
    strm_good[35:0] = S;
    strm_bad[35:0]  = S_BAD;
    if (LOAD == 72) begin
      strm_good[71:36] = S;
      strm_bad[71:36]  = S_BAD;
    end

    repeat (3) @(negedge prog_clk);
    check("reset_outputs", 80'({cfg_ready, ccff_head, ccff_shift_en, busy, done}), 80'(5'b00000));
    prog_rst_n = 1'b1;
    @(negedge prog_clk);

    // Uninterrupted load
    clear_mon();
    pulse_start();
    check("t1_ready_after_start", 80'(cfg_ready), 80'(1'b1));
    check("t1_busy_after_start", 80'(busy), 80'(1'b1));
    fork
      produce(strm_good, NW, -1, 0);
      wait_done();
    join
    check("t1_done", 80'(done), 80'(1'b1));
    check("t1_busy_low", 80'(busy), 80'(1'b0));
    check("t1_no_extra_request", 80'(cfg_ready), 80'(1'b0));
    check("t1_handshakes", 80'(hs), 80'(NW));
    check("t1_enables", 80'(nen), 80'(LOAD));
    check("t1_head_sequence", rec, strm_good);
    check("t1_enable_span", 80'(last_t - first_t + 1), 80'(SPAN));
`ifdef CCFF_READBACK_EN
    check("t1_readback_clean", 80'(readback_err), 80'(1'b0));
`endif

    // Restart from DONE, stalled word 3, and a start pulse ignored mid-load
    clear_mon();
    check("t2_done_held", 80'(done), 80'(1'b1));
    pulse_start();
    check("t2_done_cleared", 80'(done), 80'(1'b0));
    check("t2_ready_after_restart", 80'(cfg_ready), 80'(1'b1));
    fork
      produce(strm_good, NW, 3, 3);
      begin
        for (int c = 0; c < 300 && nen < 10; c++) @(negedge prog_clk);
        pulse_start();
      end
      wait_done();
    join
    check("t2_done", 80'(done), 80'(1'b1));
    check("t2_enables", 80'(nen), 80'(LOAD));
    check("t2_head_sequence", rec, strm_good);
    check("t2_enable_span_stall", 80'(last_t - first_t + 1), 80'(SPAN + 3));

    // Asynchronous reset mid-load
    clear_mon();
    pulse_start();
    fork
      produce(strm_good, NW, -1, 0);
      begin
        for (int c = 0; c < 300 && nen < 17; c++) @(negedge prog_clk);
        check("t3_busy_midload", 80'(busy), 80'(1'b1));
        #1 prog_rst_n = 1'b0;
        #1 check("t3_async_outputs_zero",
                 80'({cfg_ready, ccff_head, ccff_shift_en, busy, done}), 80'(5'b00000));
        abort_prod = 1'b1;
      end
    join
    cfg_valid  = 1'b0;
    abort_prod = 1'b0;
    repeat (2) @(negedge prog_clk);
    prog_rst_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    check("t3_idle_after_release",
          80'({cfg_ready, ccff_shift_en, busy, done}), 80'(4'b0000));

`ifdef CCFF_READBACK_EN
    // Stage 20 stuck at 0 corrupts first-pass ones, caught on the second pass
    stuck = 1'b1;
    clear_mon();
    pulse_start();
    fork
      produce(strm_bad, NW, -1, 0);
      wait_done();
    join
    check("t4_enables", 80'(nen), 80'(LOAD));
    check("t4_readback_err", 80'(readback_err), 80'(1'b1));
    repeat (3) @(negedge prog_clk);
    check("t4_readback_sticky", 80'(readback_err), 80'(1'b1));
    pulse_start();
    check("t4_readback_cleared", 80'(readback_err), 80'(1'b0));
    check("t4_ready_after_restart", 80'(cfg_ready), 80'(1'b1));
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
